dac_sample_pacer: RTL and testbench

Upstream sample source for the 10-bit DAC output core. Buffers packed sample words written from the PLB slave register/memory path and releases one sample per programmable rate tick as a registered data word plus a one-cycle strobe. The DAC core latches the data on the strobe and drives S_Data. Underrun is detected and reported, and a configurable idle code is held while the buffer is starved.

---
 rtl/dac_sample_pacer.sv | 158 +++++++++++++++
 tb/tb_dac_sample_pacer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_pacer.sv
// dac_sample_pacer
//   Buffers packed two-sample words from the PLB slave path and releases one
//   sample per programmable rate tick as a registered word plus a one-cycle
//   strobe for the DAC output core. Underruns emit an idle code and raise a
//   sticky interrupt flag.
//
// Ports
//   SPLB_Clk      single clock for all logic
//   SPLB_Rst_n    asynchronous active-low reset
//   Wr_Data       packed word [0:31]: sample0 = [32-DAC_WIDTH:31] (played
//                 first), sample1 = [16-DAC_WIDTH:15]; other bits ignored
//   Wr_Valid      word offered
//   Wr_Ready      FIFO can accept (transfer on Wr_Valid & Wr_Ready)
//   Cfg_Enable    pacer run
//   Cfg_Divider   tick period = Cfg_Divider+1 cycles
//   Cfg_Idle      code emitted on underrun
//   Underrun_Clr  clears Underrun_Irq
//   Dac_Data      registered sample to the DAC core
//   Dac_Strobe    one-cycle pulse, Dac_Data updated this cycle
//   Underrun_Irq  sticky underrun flag
//   Fifo_Level    words held (0..2^FIFO_DEPTH_LOG2)
//
// Build option
//   DAC_PACER_OFFSET_BINARY_EN: when defined, FIFO samples are treated as
//   two's complement and converted to offset binary (MSB inverted) on load.
//   Cfg_Idle is always passed through unmodified.

module dac_sample_pacer #(
    parameter int unsigned DAC_WIDTH       = 10,
    parameter int unsigned FIFO_DEPTH_LOG2 = 5,
    parameter int unsigned DIV_WIDTH       = 16
) (
    input  logic                       SPLB_Clk,
    input  logic                       SPLB_Rst_n,
    input  logic [0:31]                Wr_Data,
    input  logic                       Wr_Valid,
    output logic                       Wr_Ready,
    input  logic                       Cfg_Enable,
    input  logic [DIV_WIDTH-1:0]       Cfg_Divider,
    input  logic [DAC_WIDTH-1:0]       Cfg_Idle,
    input  logic                       Underrun_Clr,
    output logic [DAC_WIDTH-1:0]       Dac_Data,
    output logic                       Dac_Strobe,
    output logic                       Underrun_Irq,
    output logic [FIFO_DEPTH_LOG2:0]   Fifo_Level
);

    localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_LEVEL = DEPTH[FIFO_DEPTH_LOG2:0];

    logic [2*DAC_WIDTH-1:0]     mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   level;
    logic                       half;
    logic [DIV_WIDTH-1:0]       count;

    logic [DAC_WIDTH-1:0]       sample0;
    logic [DAC_WIDTH-1:0]       sample1;
    logic [DAC_WIDTH-1:0]       head_sample;
    logic [DAC_WIDTH-1:0]       load_sample;
    logic                       tick;
    logic                       have_data;
    logic                       push;
    logic                       pop;

    assign sample0 = Wr_Data[32-DAC_WIDTH:31];
    assign sample1 = Wr_Data[16-DAC_WIDTH:15];

    generate
        if (DAC_WIDTH < 16) begin : g_unused_bits
            logic unused_wr_bits;
            assign unused_wr_bits = ^{Wr_Data[0:15-DAC_WIDTH], Wr_Data[16:31-DAC_WIDTH]};
        end
    endgenerate

    // Ready depends only on the registered level, never on a same-cycle pop.
    assign Wr_Ready   = (level != FULL_LEVEL);
    assign Fifo_Level = level;

    assign tick      = Cfg_Enable && (count == '0);
    assign have_data = (level != '0);
    assign push      = Wr_Valid && Wr_Ready;
    // The head word leaves only once its second sample has been consumed.
    assign pop       = tick && have_data && half;

    assign head_sample = half ? mem[rd_ptr][2*DAC_WIDTH-1:DAC_WIDTH]
                              : mem[rd_ptr][DAC_WIDTH-1:0];

`ifdef DAC_PACER_OFFSET_BINARY_EN
    assign load_sample = head_sample ^ {1'b1, {(DAC_WIDTH-1){1'b0}}};
`else
    assign load_sample = head_sample;
`endif

    // Storage is not reset: pointers and level define what is valid.
    always_ff @(posedge SPLB_Clk) begin
        if (push) begin
            mem[wr_ptr] <= {sample1, sample0};
        end
    end

    always_ff @(posedge SPLB_Clk or negedge SPLB_Rst_n) begin
        if (!SPLB_Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    always_ff @(posedge SPLB_Clk or negedge SPLB_Rst_n) begin
        if (!SPLB_Rst_n) begin
            count <= '0;
        end else if (!Cfg_Enable) begin
            count <= '0;
        end else if (count == '0) begin
            count <= Cfg_Divider;
        end else begin
            count <= count - 1'b1;
        end
    end

    always_ff @(posedge SPLB_Clk or negedge SPLB_Rst_n) begin
        if (!SPLB_Rst_n) begin
            Dac_Data     <= '0;
            Dac_Strobe   <= 1'b0;
            Underrun_Irq <= 1'b0;
            half         <= 1'b0;
        end else begin
            Dac_Strobe <= tick;
            if (tick && have_data) begin
                Dac_Data <= load_sample;
                half     <= ~half;
            end else if (tick) begin
                Dac_Data <= Cfg_Idle;
            end
            // A new underrun in the same cycle as a clear keeps the flag set.
            if (tick && !have_data) begin
                Underrun_Irq <= 1'b1;
            end else if (Underrun_Clr) begin
                Underrun_Irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dac_sample_pacer.sv
module tb_dac_sample_pacer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        en;
    logic [15:0] div;
    logic [9:0]  idle;
    logic        clr;
    logic [9:0]  dac_data;
    logic        strobe;
    logic        irq;
    logic [5:0]  level;

    int errors = 0;
    int checks = 0;

    dac_sample_pacer #(
        .DAC_WIDTH(10),
        .FIFO_DEPTH_LOG2(5),
        .DIV_WIDTH(16)
    ) dut (
        .SPLB_Clk(clk),
        .SPLB_Rst_n(rst_n),
        .Wr_Data(wr_data),
        .Wr_Valid(wr_valid),
        .Wr_Ready(wr_ready),
        .Cfg_Enable(en),
        .Cfg_Divider(div),
        .Cfg_Idle(idle),
        .Underrun_Clr(clr),
        .Dac_Data(dac_data),
        .Dac_Strobe(strobe),
        .Underrun_Irq(irq),
        .Fifo_Level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] wdata;
        logic        en;
        logic [15:0] div;
        logic [9:0]  idle;
        logic        clr;
        logic [9:0]  e_data;
        logic        e_strobe;
        logic        e_irq;
        logic [5:0]  e_level;
        logic        e_ready;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [9:0] ob(input logic [9:0] x);
`ifdef DAC_PACER_OFFSET_BINARY_EN
        return x ^ 10'h200;
`else
        return x;
`endif
    endfunction

    function automatic logic [31:0] word(input int unsigned i);
        logic [9:0] s0;
        logic [9:0] s1;
        s0 = 10'(i);
        s1 = 10'(i + 32'h100);
        return {6'd0, s1, 6'd0, s0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        en       = 1'b0;
        div      = '0;
        idle     = '0;
        clr      = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h0155_02AA, 1'b0, 16'd3, 10'h200, 1'b0, 10'h000,     1'b0, 1'b0, 6'd1, 1'b1};
        vecs[1]  = '{1'b0, 32'h0,         1'b1, 16'd3, 10'h200, 1'b0, ob(10'h2AA), 1'b1, 1'b0, 6'd1, 1'b1};
        vecs[2]  = '{1'b0, 32'h0,         1'b1, 16'd3, 10'h200, 1'b0, ob(10'h2AA), 1'b0, 1'b0, 6'd1, 1'b1};
        vecs[3]  = '{1'b0, 32'h0,         1'b1, 16'd3, 10'h200, 1'b0, ob(10'h2AA), 1'b0, 1'b0, 6'd1, 1'b1};
        vecs[4]  = '{1'b0, 32'h0,         1'b1, 16'd3, 10'h200, 1'b0, ob(10'h2AA), 1'b0, 1'b0, 6'd1, 1'b1};
        vecs[5]  = '{1'b0, 32'h0,         1'b1, 16'd3, 10'h200, 1'b0, ob(10'h155), 1'b1, 1'b0, 6'd0, 1'b1};
        vecs[6]  = '{1'b0, 32'h0,         1'b1, 16'd3, 10'h200, 1'b0, ob(10'h155), 1'b0, 1'b0, 6'd0, 1'b1};
        vecs[7]  = '{1'b0, 32'h0,         1'b1, 16'd3, 10'h200, 1'b0, ob(10'h155), 1'b0, 1'b0, 6'd0, 1'b1};
        vecs[8]  = '{1'b0, 32'h0,         1'b1, 16'd3, 10'h200, 1'b0, ob(10'h155), 1'b0, 1'b0, 6'd0, 1'b1};
        vecs[9]  = '{1'b0, 32'h0,         1'b1, 16'd3, 10'h200, 1'b0, 10'h200,     1'b1, 1'b1, 6'd0, 1'b1};
        vecs[10] = '{1'b0, 32'h0,         1'b0, 16'd3, 10'h200, 1'b1, 10'h200,     1'b0, 1'b0, 6'd0, 1'b1};

        rst_n = 1'b0;
        do_reset();
        #1;
        chk("reset_data",   32'(dac_data), 32'h0);
        chk("reset_strobe", 32'(strobe),   32'h0);
        chk("reset_irq",    32'(irq),      32'h0);
        chk("reset_level",  32'(level),    32'h0);
        chk("reset_ready",  32'(wr_ready), 32'h1);

        // Order / rate / underrun / clear sequence
        for (int unsigned i = 0; i < 11; i++) begin
            @(negedge clk);
            wr_valid = vecs[i].valid;
            wr_data  = vecs[i].wdata;
            en       = vecs[i].en;
            div      = vecs[i].div;
            idle     = vecs[i].idle;
            clr      = vecs[i].clr;
            cycle();
            chk($sformatf("v%0d_data", i),   32'(dac_data), 32'(vecs[i].e_data));
            chk($sformatf("v%0d_strobe", i), 32'(strobe),   32'(vecs[i].e_strobe));
            chk($sformatf("v%0d_irq", i),    32'(irq),      32'(vecs[i].e_irq));
            chk($sformatf("v%0d_level", i),  32'(level),    32'(vecs[i].e_level));
            chk($sformatf("v%0d_ready", i),  32'(wr_ready), 32'(vecs[i].e_ready));
        end

        // Full: 33 writes while disabled, 33rd held until a pop
        do_reset();
        for (int unsigned i = 0; i < 33; i++) begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data  = word(i);
            cycle();
        end
        chk("full_level", 32'(level),    32'd32);
        chk("full_ready", 32'(wr_ready), 32'h0);
        cycle();
        chk("full_hold_level", 32'(level), 32'd32);
        @(negedge clk);
        en  = 1'b1;
        div = 16'd0;
        cycle();
        chk("full_t0_data",  32'(dac_data), 32'(ob(10'h000)));
        chk("full_t0_level", 32'(level),    32'd32);
        chk("full_t0_ready", 32'(wr_ready), 32'h0);
        cycle();
        chk("full_t1_data",  32'(dac_data), 32'(ob(10'h100)));
        chk("full_t1_level", 32'(level),    32'd31);
        chk("full_t1_ready", 32'(wr_ready), 32'h1);
        cycle();
        chk("full_t2_data",  32'(dac_data), 32'(ob(10'h001)));
        chk("full_t2_level", 32'(level),    32'd32);
        chk("full_t2_strobe", 32'(strobe),  32'h1);

        // Asynchronous reset mid-stream
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_data",   32'(dac_data), 32'h0);
        chk("arst_strobe", 32'(strobe),   32'h0);
        chk("arst_level",  32'(level),    32'h0);
        chk("arst_ready",  32'(wr_ready), 32'h1);
        chk("arst_irq",    32'(irq),      32'h0);

        // Underrun with clear asserted during the underrun tick
        do_reset();
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = 32'h0155_02AA;
        cycle();
        @(negedge clk);
        wr_valid = 1'b0;
        en       = 1'b1;
        div      = 16'd0;
        idle     = 10'h200;
        clr      = 1'b1;
        cycle();
        chk("ur_s0", 32'(dac_data), 32'(ob(10'h2AA)));
        cycle();
        chk("ur_s1", 32'(dac_data), 32'(ob(10'h155)));
        chk("ur_s1_level", 32'(level), 32'h0);
        cycle();
        chk("ur_idle",   32'(dac_data), 32'h200);
        chk("ur_strobe", 32'(strobe),   32'h1);
        chk("ur_irq_set_wins", 32'(irq), 32'h1);
        @(negedge clk);
        en = 1'b0;
        cycle();
        chk("ur_irq_cleared", 32'(irq), 32'h0);
        chk("ur_no_strobe", 32'(strobe), 32'h0);

        // Push and pop in the same cycle at level 1
        do_reset();
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = word(5);
        cycle();
        @(negedge clk);
        wr_valid = 1'b0;
        en       = 1'b1;
        div      = 16'd0;
        cycle();
        chk("pp_first_level", 32'(level), 32'd1);
        for (int unsigned k = 0; k < 4; k++) begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data  = word(6 + k);
            cycle();
            chk($sformatf("pp%0d_pop_level", k),  32'(level),    32'd1);
            chk($sformatf("pp%0d_pop_strobe", k), 32'(strobe),   32'h1);
            chk($sformatf("pp%0d_pop_data", k),   32'(dac_data), 32'(ob(10'(32'h100 + 5 + k))));
            @(negedge clk);
            wr_valid = 1'b0;
            cycle();
            chk($sformatf("pp%0d_mid_level", k),  32'(level),    32'd1);
            chk($sformatf("pp%0d_mid_strobe", k), 32'(strobe),   32'h1);
            chk($sformatf("pp%0d_mid_data", k),   32'(dac_data), 32'(ob(10'(6 + k))));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
